// File: rtl/multicycle_ctrl_pkg.sv
// Shared encodings for the multi-cycle main control FSM: opcodes, ALU class,
// PC source select and state encoding.
package multicycle_ctrl_pkg;

    // Instruction opcodes, instr[15:12]
    localparam logic [3:0] OP_LD    = 4'b0000;
    localparam logic [3:0] OP_ST    = 4'b0001;
    localparam logic [3:0] OP_R_MIN = 4'b0010;
    localparam logic [3:0] OP_R_MAX = 4'b1001;
    localparam logic [3:0] OP_BEQ   = 4'b1011;
    localparam logic [3:0] OP_BNE   = 4'b1100;
    localparam logic [3:0] OP_JMP   = 4'b1101;

    // Operation class handed to the ALU control decoder
    localparam logic [1:0] ALUOP_R   = 2'b00;
    localparam logic [1:0] ALUOP_BR  = 2'b01;
    localparam logic [1:0] ALUOP_MEM = 2'b10;

    // PC source select
    localparam logic [1:0] PCSRC_SEQ = 2'b00;  // PC+2
    localparam logic [1:0] PCSRC_BR  = 2'b01;  // branch target
    localparam logic [1:0] PCSRC_JMP = 2'b10;  // jump target

    typedef enum logic [2:0] {
        ST_BOOT   = 3'd0,
        ST_FETCH  = 3'd1,
        ST_DECODE = 3'd2,
        ST_EXEC   = 3'd3,
        ST_MEM    = 3'd4,
        ST_WB     = 3'd5,
        ST_TRAP   = 3'd6
    } state_e;

    function automatic logic is_rtype(input logic [3:0] op);
        return (op >= OP_R_MIN) && (op <= OP_R_MAX);
    endfunction

    function automatic logic is_mem(input logic [3:0] op);
        return (op == OP_LD) || (op == OP_ST);
    endfunction

    // 1010, 1110 and 1111 have no instruction assigned
    function automatic logic is_illegal(input logic [3:0] op);
        return !(is_rtype(op) || is_mem(op) ||
                 op == OP_BEQ || op == OP_BNE || op == OP_JMP);
    endfunction

endpackage

// File: rtl/multicycle_ctrl_wait_timer.sv
// Memory-wait watchdog counter: clears on request, counts cycles without an
// ack, and flags when TIMEOUT-1 cycles have already elapsed.
// TIMEOUT must be >= 2 and 2**CNT_W must exceed TIMEOUT.
module wait_timer #(
    parameter int TIMEOUT = 16,
    parameter int CNT_W   = 5
) (
    input  logic clk,
    input  logic rst,
    input  logic clr_i,
    input  logic en_i,
    output logic timeout_o
);

    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;

    // Next count: clear has priority over increment
    always_comb begin
        cnt_d = cnt_q;
        if (clr_i) begin
            cnt_d = '0;
        end else if (en_i) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    // Counter register with synchronous reset
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign timeout_o = (cnt_q == CNT_W'(TIMEOUT - 1));

endmodule

// File: rtl/multicycle_ctrl.sv
// Multi-cycle main control FSM for the 16-bit RISC core. Walks each
// instruction through FETCH/DECODE/EXEC/MEM/WB, drives datapath enables and
// memory handshakes, and traps on illegal opcodes or a hung memory.
module multicycle_ctrl
    import multicycle_ctrl_pkg::*;
#(
    parameter int TIMEOUT = 16,
    parameter int CNT_W   = 5
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [3:0] instr_op,
    input  logic       imem_ack,
    input  logic       dmem_ack,
    input  logic       zero,
    output logic       imem_req,
    output logic       dmem_req,
    output logic       dmem_we,
    output logic       ir_load,
    output logic [1:0] alu_op,
    output logic [3:0] opcode,
    output logic       reg_write,
    output logic       mem_to_reg,
    output logic       pc_write,
    output logic [1:0] pc_src,
    output logic       trap
);

    state_e     state_q, state_d;
    logic [3:0] opcode_q, opcode_d;
    logic       wait_clr;
    logic       wait_en;
    logic       wait_timeout;

    // Restart the watchdog on every state change so FETCH and MEM start at 0;
    // count only while a memory request is outstanding and unanswered.
    assign wait_clr = (state_d != state_q);
    assign wait_en  = ((state_q == ST_FETCH) && !imem_ack) ||
                      ((state_q == ST_MEM)   && !dmem_ack);

    wait_timer #(
        .TIMEOUT (TIMEOUT),
        .CNT_W   (CNT_W)
    ) u_wait_timer (
        .clk       (clk),
        .rst       (rst),
        .clr_i     (wait_clr),
        .en_i      (wait_en),
        .timeout_o (wait_timeout)
    );

    // State and opcode registers
    // NOTE: sequential state uses non-blocking (<=) so every register samples
    // pre-edge values; blocking here would create order-dependent races.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= ST_BOOT;
            opcode_q <= '0;
        end else begin
            state_q  <= state_d;
            opcode_q <= opcode_d;
        end
    end

    // Next-state and Moore output decode (fetch enables qualified by the ack)
    // NOTE: every output gets a default before the case so no path leaves a
    // signal unassigned, which would otherwise infer a latch.
    always_comb begin
        state_d    = state_q;
        opcode_d   = opcode_q;
        imem_req   = 1'b0;
        dmem_req   = 1'b0;
        dmem_we    = 1'b0;
        ir_load    = 1'b0;
        alu_op     = ALUOP_R;
        reg_write  = 1'b0;
        mem_to_reg = 1'b0;
        pc_write   = 1'b0;
        pc_src     = PCSRC_SEQ;
        trap       = 1'b0;

        unique case (state_q)
            ST_BOOT: begin
                state_d = ST_FETCH;
            end

            ST_FETCH: begin
                imem_req = 1'b1;
                if (imem_ack) begin
                    // An ack on the timeout cycle still wins
                    ir_load  = 1'b1;
                    pc_write = 1'b1;
                    pc_src   = PCSRC_SEQ;
                    opcode_d = instr_op;
                    state_d  = ST_DECODE;
                end else if (wait_timeout) begin
                    state_d = ST_TRAP;
                end
            end

            ST_DECODE: begin
                state_d = is_illegal(opcode_q) ? ST_TRAP : ST_EXEC;
            end

            ST_EXEC: begin
                if (is_mem(opcode_q)) begin
                    alu_op  = ALUOP_MEM;
                    state_d = ST_MEM;
                end else if (opcode_q == OP_BEQ) begin
                    alu_op   = ALUOP_BR;
                    pc_src   = PCSRC_BR;
                    pc_write = zero;
                    state_d  = ST_FETCH;
                end else if (opcode_q == OP_BNE) begin
                    alu_op   = ALUOP_BR;
                    pc_src   = PCSRC_BR;
                    pc_write = ~zero;
                    state_d  = ST_FETCH;
                end else if (opcode_q == OP_JMP) begin
                    pc_src   = PCSRC_JMP;
                    pc_write = 1'b1;
                    state_d  = ST_FETCH;
                end else if (is_rtype(opcode_q)) begin
                    alu_op  = ALUOP_R;
                    state_d = ST_WB;
                end else begin
                    // Unreachable: DECODE filters illegal opcodes
                    state_d = ST_TRAP;
                end
            end

            ST_MEM: begin
                dmem_req = 1'b1;
                dmem_we  = (opcode_q == OP_ST);
                if (dmem_ack) begin
                    state_d = (opcode_q == OP_ST) ? ST_FETCH : ST_WB;
                end else if (wait_timeout) begin
                    state_d = ST_TRAP;
                end
            end

            ST_WB: begin
                reg_write  = 1'b1;
                mem_to_reg = (opcode_q == OP_LD);
                state_d    = ST_FETCH;
            end

            ST_TRAP: begin
                // Sticky: only rst leaves this state
                trap = 1'b1;
            end

            default: begin
                state_d = ST_BOOT;
            end
        endcase
    end

    // The trap state forces every output except trap to zero
    assign opcode = (state_q == ST_TRAP) ? 4'b0000 : opcode_q;

endmodule

// File: tb/tb_multicycle_ctrl.sv
// Directed self-checking bench for multicycle_ctrl. Inputs are driven and
// outputs sampled on the falling edge; the DUT updates on the rising edge.
module tb_multicycle_ctrl;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [3:0] instr_op = 4'h0;
    logic       imem_ack = 1'b0;
    logic       dmem_ack = 1'b0;
    logic       zero = 1'b0;
    logic       imem_req, dmem_req, dmem_we, ir_load;
    logic [1:0] alu_op;
    logic [3:0] opcode;
    logic       reg_write, mem_to_reg, pc_write;
    logic [1:0] pc_src;
    logic       trap;

    int checks = 0;
    int errors = 0;

    multicycle_ctrl #(.TIMEOUT(16), .CNT_W(5)) dut (
        .clk        (clk),
        .rst        (rst),
        .instr_op   (instr_op),
        .imem_ack   (imem_ack),
        .dmem_ack   (dmem_ack),
        .zero       (zero),
        .imem_req   (imem_req),
        .dmem_req   (dmem_req),
        .dmem_we    (dmem_we),
        .ir_load    (ir_load),
        .alu_op     (alu_op),
        .opcode     (opcode),
        .reg_write  (reg_write),
        .mem_to_reg (mem_to_reg),
        .pc_write   (pc_write),
        .pc_src     (pc_src),
        .trap       (trap)
    );

    always #5 clk = ~clk;

    // Packed view of all single-cycle outputs except opcode
    logic [11:0] outs;
    assign outs = {imem_req, dmem_req, dmem_we, ir_load, alu_op,
                   reg_write, mem_to_reg, pc_write, pc_src, trap};

    function automatic logic [11:0] ov(
        input logic ir, input logic dr, input logic we, input logic irl,
        input logic [1:0] alu, input logic rw, input logic m2r,
        input logic pcw, input logic [1:0] pcs, input logic tr);
        return {ir, dr, we, irl, alu, rw, m2r, pcw, pcs, tr};
    endfunction

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // Drive inputs for one cycle on the falling edge, settle, return
    task automatic drive(input logic ia, input logic da, input logic z,
                         input logic [3:0] op);
        @(negedge clk);
        imem_ack = ia;
        dmem_ack = da;
        zero     = z;
        instr_op = op;
        #1;
    endtask

    // FETCH with immediate ack, then the DECODE cycle; leaves DUT entering EXEC
    task automatic fetch_op(input logic [3:0] op, input string tag);
        drive(1'b1, 1'b0, 1'b0, op);
        check({tag, " fetch"}, 32'(outs), 32'(ov(1,0,0,1,2'b00,0,0,1,2'b00,0)));
        drive(1'b0, 1'b0, 1'b0, 4'h0);
        check({tag, " decode"}, 32'(outs), 32'h0);
        check({tag, " opcode"}, 32'(opcode), 32'(op));
    endtask

    // Assert rst for one edge, check the post-reset cycle, release into BOOT
    task automatic reset_seq(input string tag);
        @(negedge clk);
        rst = 1'b1; imem_ack = 1'b0; dmem_ack = 1'b0; zero = 1'b0;
        #1;
        drive(1'b0, 1'b0, 1'b0, 4'h0);
        check({tag, " in reset"}, 32'(outs), 32'h0);
        check({tag, " opcode clr"}, 32'(opcode), 32'h0);
        @(negedge clk);
        rst = 1'b0;
        #1;
        check({tag, " boot"}, 32'(outs), 32'h0);
    endtask

    initial begin
        #100000;
        $display("FAIL global timeout");
        $fatal(1);
    end

    initial begin
        // Reset held, then released
        for (int i = 0; i < 3; i++) begin
            drive(1'b0, 1'b0, 1'b0, 4'h0);
            check("reset outs", 32'(outs), 32'h0);
        end
        @(negedge clk);
        rst = 1'b0;
        #1;
        check("boot outs", 32'(outs), 32'h0);

        // ADD: FETCH, DECODE, EXEC, WB, then next FETCH
        fetch_op(4'b0010, "add");
        drive(1'b0, 1'b0, 1'b0, 4'h0);
        check("add exec", 32'(outs), 32'h0);
        check("add exec opcode", 32'(opcode), 32'h2);
        drive(1'b0, 1'b0, 1'b0, 4'h0);
        check("add wb", 32'(outs), 32'(ov(0,0,0,0,2'b00,1,0,0,2'b00,0)));
        // Stray dmem_ack in FETCH must be ignored
        drive(1'b0, 1'b1, 1'b0, 4'h0);
        check("add next fetch", 32'(outs), 32'(ov(1,0,0,0,2'b00,0,0,0,2'b00,0)));

        // LD with dmem_ack after 3 wait cycles
        fetch_op(4'b0000, "ld");
        drive(1'b0, 1'b0, 1'b0, 4'h0);
        check("ld exec", 32'(outs), 32'(ov(0,0,0,0,2'b10,0,0,0,2'b00,0)));
        for (int i = 0; i < 4; i++) begin
            drive(1'b0, (i == 3), 1'b0, 4'h0);
            check("ld mem", 32'(outs), 32'(ov(0,1,0,0,2'b00,0,0,0,2'b00,0)));
        end
        drive(1'b0, 1'b0, 1'b0, 4'h0);
        check("ld wb", 32'(outs), 32'(ov(0,0,0,0,2'b00,1,1,0,2'b00,0)));

        // ST with dmem_ack after 3 wait cycles, no WB
        fetch_op(4'b0001, "st");
        drive(1'b0, 1'b0, 1'b0, 4'h0);
        check("st exec", 32'(outs), 32'(ov(0,0,0,0,2'b10,0,0,0,2'b00,0)));
        for (int i = 0; i < 4; i++) begin
            drive(1'b0, (i == 3), 1'b0, 4'h0);
            check("st mem", 32'(outs), 32'(ov(0,1,1,0,2'b00,0,0,0,2'b00,0)));
        end
        drive(1'b0, 1'b0, 1'b0, 4'h0);
        check("st next fetch", 32'(outs), 32'(ov(1,0,0,0,2'b00,0,0,0,2'b00,0)));

        // Branches: {opcode, zero, expected pc_write}
        fetch_op(4'b1011, "beq z1");
        drive(1'b0, 1'b0, 1'b1, 4'h0);
        check("beq z1 exec", 32'(outs), 32'(ov(0,0,0,0,2'b01,0,0,1,2'b01,0)));
        fetch_op(4'b1011, "beq z0");
        drive(1'b0, 1'b0, 1'b0, 4'h0);
        check("beq z0 exec", 32'(outs), 32'(ov(0,0,0,0,2'b01,0,0,0,2'b01,0)));
        fetch_op(4'b1100, "bne z1");
        drive(1'b0, 1'b0, 1'b1, 4'h0);
        check("bne z1 exec", 32'(outs), 32'(ov(0,0,0,0,2'b01,0,0,0,2'b01,0)));
        fetch_op(4'b1100, "bne z0");
        drive(1'b0, 1'b0, 1'b0, 4'h0);
        check("bne z0 exec", 32'(outs), 32'(ov(0,0,0,0,2'b01,0,0,1,2'b01,0)));
        fetch_op(4'b1101, "jmp");
        drive(1'b0, 1'b0, 1'b0, 4'h0);
        check("jmp exec", 32'(outs), 32'(ov(0,0,0,0,2'b00,0,0,1,2'b10,0)));

        // Illegal opcode traps and stays trapped whatever the inputs do
        fetch_op(4'b1110, "illegal");
        for (int i = 0; i < 3; i++) begin
            drive(1'b1, 1'b1, 1'b1, 4'h2);
            check("trap sticky", 32'(outs), 32'(ov(0,0,0,0,2'b00,0,0,0,2'b00,1)));
        end
        reset_seq("trap rst");

        // Fetch ack withheld: 16 FETCH cycles, then TRAP
        for (int i = 0; i < 16; i++) begin
            drive(1'b0, 1'b0, 1'b0, 4'h0);
            check("wd fetch", 32'(outs), 32'(ov(1,0,0,0,2'b00,0,0,0,2'b00,0)));
        end
        drive(1'b0, 1'b0, 1'b0, 4'h0);
        check("wd trap", 32'(outs), 32'(ov(0,0,0,0,2'b00,0,0,0,2'b00,1)));
        reset_seq("wd rst");

        // Ack arriving on the 16th FETCH cycle wins over the timeout
        for (int i = 0; i < 15; i++) begin
            drive(1'b0, 1'b0, 1'b0, 4'h0);
        end
        check("late fetch pre", 32'(outs), 32'(ov(1,0,0,0,2'b00,0,0,0,2'b00,0)));
        fetch_op(4'b0011, "late ack");
        drive(1'b0, 1'b0, 1'b0, 4'h0);
        check("late exec", 32'(outs), 32'h0);
        drive(1'b0, 1'b0, 1'b0, 4'h0);
        check("late wb", 32'(outs), 32'(ov(0,0,0,0,2'b00,1,0,0,2'b00,0)));

        // Reset in the middle of a load's MEM phase
        fetch_op(4'b0000, "ld rst");
        drive(1'b0, 1'b0, 1'b0, 4'h0);
        drive(1'b0, 1'b0, 1'b0, 4'h0);
        check("ld rst mem", 32'(outs), 32'(ov(0,1,0,0,2'b00,0,0,0,2'b00,0)));
        reset_seq("mid rst");
        drive(1'b0, 1'b0, 1'b0, 4'h0);
        check("mid rst fetch", 32'(outs), 32'(ov(1,0,0,0,2'b00,0,0,0,2'b00,0)));

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
